// File: rtl/cdm_bus_unit.sv
// cdm_bus_unit -- load/store bus unit for the cdm core.
//  Takes one access from the core, splits lane-boundary-crossing accesses into
//  two aligned beats, waits on mem_ready (optional per-beat timeout), merges and
//  sign/zero-extends read data, and reports misaligned / bad-size / timeout faults.
// Ports:
//  input_clock, reset_n              clock, async active-low reset
//  req/we/size/sign_extend/addr/wdata core request (sampled only while idle)
//  rdata/done/fault/fault_code/busy  core response
//  mem_req/mem_we/mem_addr/mem_be/mem_wdata/mem_rdata/mem_ready  memory beat port

// Per-lane slice: byte enable, write-data rotation and read merge for one lane.
//  off   : byte offset of the access inside the bus word
//  end_b : off + access size in bytes (may exceed NUM_LANES when split)
module cdm_bus_lane #(
  parameter int NUM_LANES = 2,
  parameter int OW        = 1,
  parameter int LANE      = 0
) (
  input  logic [OW-1:0]               off,
  input  logic [3:0]                  end_b,
  input  logic                        beat1,
  input  logic [NUM_LANES-1:0][7:0]   wdata,
  input  logic [7:0]                  hold,
  input  logic [7:0]                  mrd,
  output logic                        be,
  output logic [7:0]                  wbyte,
  output logic [7:0]                  mbyte
);
  localparam logic [OW-1:0] LIDX = OW'(LANE);
  localparam logic [3:0]    L4   = 4'(LANE);
  localparam logic [3:0]    NL4  = 4'(NUM_LANES);

  logic [OW-1:0] wsel;

  // rotate-left by off: lane L carries source byte (L - off) mod NUM_LANES
  assign wsel  = LIDX - off;
  assign wbyte = wdata[wsel];

  // second beat covers the bytes that spilled past the top lane
  assign be = beat1 ? ((L4 + NL4) < end_b)
                    : ((L4 >= 4'(off)) && (L4 < end_b));

  // in the second beat, lanes >= off came from the first beat's holding register
  assign mbyte = (beat1 && (LIDX >= off)) ? hold : mrd;
endmodule

module cdm_bus_unit #(
  parameter int DATA_W          = 16,
  parameter int ADDR_W          = 16,
  parameter int ALLOW_UNALIGNED = 1,
  parameter int TIMEOUT         = 0
) (
  input  logic                  input_clock,
  input  logic                  reset_n,
  input  logic                  req,
  input  logic                  we,
  input  logic [1:0]            size,
  input  logic                  sign_extend,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata,
  output logic                  done,
  output logic                  fault,
  output logic [1:0]            fault_code,
  output logic                  busy,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W/8-1:0]   mem_be,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_ready
);
  localparam int NUM_LANES = DATA_W / 8;
  localparam int OW        = (NUM_LANES > 2) ? $clog2(NUM_LANES) : 1;
  localparam int CW        = $clog2(TIMEOUT + 2);
  localparam logic [CW-1:0] TLIM = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam logic [3:0]    NL4  = 4'(NUM_LANES);

  typedef enum logic [1:0] {S_IDLE, S_BEAT0, S_BEAT1, S_RESP} state_t;

  state_t                      state_q, state_d;
  logic [ADDR_W-1:0]           addr_q, addr_d;
  logic                        we_q, we_d;
  logic [1:0]                  size_q, size_d;
  logic                        sext_q, sext_d;
  logic [NUM_LANES-1:0][7:0]   wdata_q, wdata_d;
  logic [NUM_LANES-1:0][7:0]   hold_q, hold_d;
  logic [DATA_W-1:0]           rdata_q, rdata_d;
  logic                        fault_q, fault_d;
  logic [1:0]                  fcode_q, fcode_d;
  logic [CW-1:0]               tmo_q, tmo_d;

  // geometry of the captured access
  logic [OW-1:0]  off;
  logic [3:0]     nbytes, end_b;
  logic           split;
  // geometry of the incoming request (decides the IDLE exit)
  logic [3:0]     in_n, in_end;
  logic           in_bad, in_split;

  logic                        beat, beat1;
  logic [ADDR_W-1:0]           base;
  logic [NUM_LANES-1:0]        lane_be;
  logic [NUM_LANES-1:0][7:0]   lane_wd, merge, rot, rd_res;
  logic [OW-1:0]               top_idx;
  logic [7:0]                  fill;

  assign off    = addr_q[OW-1:0];
  assign nbytes = 4'(1) << size_q;
  assign end_b  = 4'(off) + nbytes;
  assign split  = end_b > NL4;

  assign in_n     = 4'(1) << size;
  assign in_end   = 4'(addr[OW-1:0]) + in_n;
  assign in_bad   = in_n > NL4;
  assign in_split = in_end > NL4;

  assign beat  = (state_q == S_BEAT0) || (state_q == S_BEAT1);
  assign beat1 = (state_q == S_BEAT1);
  assign base  = {addr_q[ADDR_W-1:OW], {OW{1'b0}}};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    cdm_bus_lane #(.NUM_LANES(NUM_LANES), .OW(OW), .LANE(g)) u_lane (
      .off   (off),
      .end_b (end_b),
      .beat1 (beat1),
      .wdata (wdata_q),
      .hold  (hold_q[g]),
      .mrd   (mem_rdata[8*g +: 8]),
      .be    (lane_be[g]),
      .wbyte (lane_wd[g]),
      .mbyte (merge[g])
    );
  end

  // rotate the merged word right by off, then extend above the access size
  assign top_idx = OW'(nbytes - 4'd1);
  always_comb begin
    rot    = '0;
    rd_res = '0;
    for (int j = 0; j < NUM_LANES; j++) rot[j] = merge[OW'(j) + off];
    fill = (sext_q && rot[top_idx][7]) ? 8'hFF : 8'h00;
    for (int j = 0; j < NUM_LANES; j++) rd_res[j] = (4'(j) < nbytes) ? rot[j] : fill;
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    size_d  = size_q;
    sext_d  = sext_q;
    wdata_d = wdata_q;
    hold_d  = hold_q;
    rdata_d = rdata_q;
    fault_d = fault_q;
    fcode_d = fcode_q;
    tmo_d   = tmo_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          addr_d  = addr;
          we_d    = we;
          size_d  = size;
          sext_d  = sign_extend;
          wdata_d = wdata;
          fault_d = 1'b0;
          fcode_d = 2'd0;
          tmo_d   = '0;
          if (in_bad) begin
            fault_d = 1'b1;
            fcode_d = 2'd2;
            state_d = S_RESP;
          end else if (in_split && (ALLOW_UNALIGNED == 0)) begin
            fault_d = 1'b1;
            fcode_d = 2'd1;
            state_d = S_RESP;
          end else begin
            state_d = S_BEAT0;
          end
        end
      end
      S_BEAT0, S_BEAT1: begin
        if (mem_ready) begin
          tmo_d = '0;
          if (!beat1) hold_d = mem_rdata;
          if (!beat1 && split) begin
            state_d = S_BEAT1;
          end else begin
            state_d = S_RESP;
            if (!we_q) rdata_d = rd_res;
          end
        end else if ((TIMEOUT != 0) && (tmo_q == TLIM)) begin
          // a finished first write beat stays written; only the access faults
          fault_d = 1'b1;
          fcode_d = 2'd3;
          state_d = S_RESP;
        end else if (TIMEOUT != 0) begin
          tmo_d = tmo_q + CW'(1);
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge input_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      size_q  <= '0;
      sext_q  <= 1'b0;
      wdata_q <= '0;
      hold_q  <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
      fcode_q <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      size_q  <= size_d;
      sext_q  <= sext_d;
      wdata_q <= wdata_d;
      hold_q  <= hold_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
      fcode_q <= fcode_d;
      tmo_q   <= tmo_d;
    end
  end

  // all memory-side outputs are gated by the beat states so they read 0 outside a beat
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_RESP);
  assign fault      = done & fault_q;
  assign fault_code = fault ? fcode_q : 2'd0;
  assign rdata      = rdata_q;
  assign mem_req    = beat;
  assign mem_we     = beat & we_q;
  assign mem_addr   = beat ? (beat1 ? base + ADDR_W'(NUM_LANES) : base) : '0;
  assign mem_be     = beat ? lane_be : '0;
  assign mem_wdata  = beat ? lane_wd : '0;
endmodule

// File: tb/tb_cdm_bus_unit.sv
module tb_cdm_bus_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_a, req_b, we, sext;
  logic [1:0]  size;
  logic [15:0] addr, wdata, mrd_a, mrd_b;
  logic        rdy_a, rdy_b;

  logic [15:0] rdata_a, rdata_b, mem_addr_a, mem_addr_b, mem_wdata_a, mem_wdata_b;
  logic        done_a, done_b, fault_a, fault_b, busy_a, busy_b;
  logic        mem_req_a, mem_req_b, mem_we_a, mem_we_b;
  logic [1:0]  fcode_a, fcode_b, mem_be_a, mem_be_b;

  typedef struct {
    logic [15:0] rdata;
    logic        fault;
    logic [1:0]  code;
  } exp_t;
  exp_t exp_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  // A: default configuration (split allowed, no timeout)
  cdm_bus_unit #(.DATA_W(16), .ADDR_W(16), .ALLOW_UNALIGNED(1), .TIMEOUT(0)) u_a (
    .input_clock(clk), .reset_n(rst_n), .req(req_a), .we(we), .size(size),
    .sign_extend(sext), .addr(addr), .wdata(wdata), .rdata(rdata_a), .done(done_a),
    .fault(fault_a), .fault_code(fcode_a), .busy(busy_a), .mem_req(mem_req_a),
    .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_be(mem_be_a), .mem_wdata(mem_wdata_a),
    .mem_rdata(mrd_a), .mem_ready(rdy_a));

  // B: crossing accesses fault, 4-cycle beat timeout
  cdm_bus_unit #(.DATA_W(16), .ADDR_W(16), .ALLOW_UNALIGNED(0), .TIMEOUT(4)) u_b (
    .input_clock(clk), .reset_n(rst_n), .req(req_b), .we(we), .size(size),
    .sign_extend(sext), .addr(addr), .wdata(wdata), .rdata(rdata_b), .done(done_b),
    .fault(fault_b), .fault_code(fcode_b), .busy(busy_b), .mem_req(mem_req_b),
    .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_be(mem_be_b), .mem_wdata(mem_wdata_b),
    .mem_rdata(mrd_b), .mem_ready(rdy_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // all driving and checking happens at negedge; req lasts one sample
  task automatic tick();
    @(negedge clk);
    cyc++;
    req_a = 1'b0;
    req_b = 1'b0;
  endtask

  task automatic issue(input bit sel, input logic w, input logic [1:0] sz, input logic sx,
                       input logic [15:0] a, input logic [15:0] wd,
                       input logic [15:0] e_rd, input logic e_f, input logic [1:0] e_c,
                       input bit push);
    exp_t e;
    we = w; size = sz; sext = sx; addr = a; wdata = wd;
    if (sel) req_b = 1'b1; else req_a = 1'b1;
    cyc = 0;
    if (push) begin
      e.rdata = e_rd; e.fault = e_f; e.code = e_c;
      exp_q.push_back(e);
    end
  endtask

  task automatic expect_done(input bit sel, input string tag, input int exp_cyc);
    exp_t e;
    while (!(sel ? done_b : done_a) && cyc < 40) tick();
    chk({tag, "_latency"}, cyc, exp_cyc);
    chk({tag, "_mreq_in_resp"}, sel ? mem_req_b : mem_req_a, 1'b0);
    n_cmp++;
    assert (exp_q.size() > 0) else begin
      n_err++;
      $error("FAIL %s_scoreboard: got empty queue want one entry", tag);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_rdata"}, sel ? rdata_b : rdata_a, e.rdata);
      chk({tag, "_fault"}, sel ? fault_b : fault_a, e.fault);
      chk({tag, "_code"},  sel ? fcode_b : fcode_a, e.code);
    end
    tick();
    chk({tag, "_done_pulse"}, sel ? done_b : done_a, 1'b0);
    chk({tag, "_idle"},       sel ? busy_b : busy_a, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1;
    req_a = 0; req_b = 0; we = 0; sext = 0; size = 0; addr = 0; wdata = 0;
    mrd_a = 0; mrd_b = 0; rdy_a = 0; rdy_b = 0;
    #1 rst_n = 1'b0;
    tick(); tick();
    chk("rst_a_ctl", {rdata_a, done_a, fault_a, fcode_a, busy_a, mem_req_a, mem_we_a, mem_be_a}, 0);
    chk("rst_a_addr", mem_addr_a, 0);
    chk("rst_a_wdata", mem_wdata_a, 0);
    chk("rst_b_ctl", {rdata_b, done_b, fault_b, fcode_b, busy_b, mem_req_b, mem_we_b, mem_be_b}, 0);
    rst_n = 1'b1;
    tick();

    // 1: aligned half read
    rdy_a = 1; mrd_a = 16'hBEEF;
    issue(0, 0, 2'd1, 0, 16'h0010, 16'h0, 16'hBEEF, 0, 2'd0, 1);
    tick();
    chk("t1_mreq", mem_req_a, 1);
    chk("t1_maddr", mem_addr_a, 16'h0010);
    chk("t1_be", mem_be_a, 2'b11);
    expect_done(0, "t1", 2);

    // 2: split half write, rdata keeps the previous read
    issue(0, 1, 2'd1, 0, 16'h0021, 16'h1234, 16'hBEEF, 0, 2'd0, 1);
    tick();
    chk("t2_b0_addr", mem_addr_a, 16'h0020);
    chk("t2_b0_be", mem_be_a, 2'b10);
    chk("t2_b0_wdata", mem_wdata_a, 16'h3412);
    chk("t2_b0_we", mem_we_a, 1);
    tick();
    chk("t2_b1_addr", mem_addr_a, 16'h0022);
    chk("t2_b1_be", mem_be_a, 2'b01);
    chk("t2_b1_wdata", mem_wdata_a, 16'h3412);
    expect_done(0, "t2", 3);

    // 3: split half read with two wait cycles in the second beat; a req while busy is dropped
    rdy_a = 1; mrd_a = 16'hAB00;
    issue(0, 0, 2'd1, 0, 16'h0021, 16'h0, 16'hCDAB, 0, 2'd0, 1);
    tick();
    chk("t3_b0_be", mem_be_a, 2'b10);
    tick();
    chk("t3_b1_addr", mem_addr_a, 16'h0022);
    chk("t3_b1_be", mem_be_a, 2'b01);
    rdy_a = 0; mrd_a = 16'h7777;
    tick();
    chk("t3_wait_mreq", mem_req_a, 1);
    chk("t3_wait_addr", mem_addr_a, 16'h0022);
    addr = 16'h0050; req_a = 1;
    tick();
    rdy_a = 1; mrd_a = 16'h00CD;
    expect_done(0, "t3", 5);
    tick();
    chk("t3_no_queued_req", mem_req_a, 0);

    // 4: byte reads with and without sign extension
    rdy_a = 1; mrd_a = 16'h8000;
    issue(0, 0, 2'd0, 1, 16'h0003, 16'h0, 16'hFF80, 0, 2'd0, 1);
    tick();
    chk("t4a_be", mem_be_a, 2'b10);
    expect_done(0, "t4a", 2);
    issue(0, 0, 2'd0, 0, 16'h0003, 16'h0, 16'h0080, 0, 2'd0, 1);
    expect_done(0, "t4b", 2);
    mrd_a = 16'h127F;
    issue(0, 0, 2'd0, 1, 16'h0002, 16'h0, 16'h007F, 0, 2'd0, 1);
    tick();
    chk("t4c_be", mem_be_a, 2'b01);
    expect_done(0, "t4c", 2);

    // 5: faults on the strict / timeout instance
    rdy_b = 1; mrd_b = 16'hC300;
    issue(1, 0, 2'd1, 0, 16'h0001, 16'h0, 16'h0000, 1, 2'd1, 1);
    tick();
    chk("t5a_no_mreq", mem_req_b, 0);
    expect_done(1, "t5a", 1);
    issue(1, 0, 2'd2, 0, 16'h0004, 16'h0, 16'h0000, 1, 2'd2, 1);
    tick();
    chk("t5b_no_mreq", mem_req_b, 0);
    expect_done(1, "t5b", 1);
    rdy_b = 0;
    issue(1, 0, 2'd1, 0, 16'h0030, 16'h0, 16'h0000, 1, 2'd3, 1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("t5c_mreq_c%0d", k), mem_req_b, 1);
    end
    expect_done(1, "t5c", 5);
    rdy_b = 1;
    issue(1, 0, 2'd0, 1, 16'h0001, 16'h0, 16'hFFC3, 0, 2'd0, 1);
    tick();
    chk("t5d_be", mem_be_b, 2'b10);
    expect_done(1, "t5d", 2);

    // 6: reset while waiting in the second beat
    rdy_a = 1; mrd_a = 16'hAB00;
    issue(0, 0, 2'd1, 0, 16'h0021, 16'h0, 16'h0, 0, 2'd0, 0);
    tick();
    tick();
    rdy_a = 0;
    tick();
    chk("t6_mreq_before", mem_req_a, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_mreq_async", mem_req_a, 0);
    chk("t6_busy_async", busy_a, 0);
    tick();
    chk("t6_no_done", done_a, 0);
    rst_n = 1'b1;
    tick();
    chk("t6_no_done_after", done_a, 0);
    rdy_a = 1; mrd_a = 16'h5A5A;
    issue(0, 0, 2'd1, 0, 16'h0040, 16'h0, 16'h5A5A, 0, 2'd0, 1);
    expect_done(0, "t6", 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
